// File: rtl/booth_multiplier_seq_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM state encoding,
// Booth pair codes and the step count. Optional feature macro: BOOTH_UNSIGNED_EN.
package booth_multiplier_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } state_e;

  // {Q[0], q_1} pairs that trigger an add or a subtract; the others only shift
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

  // Unsigned support widens the multiplier by one bit, costing one extra step for every op
  function automatic int steps_for(input int width);
`ifdef BOOTH_UNSIGNED_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/booth_multiplier_seq_if.sv
// Operand/product handshake bundle for booth_multiplier_seq.
// in_unsigned exists only when BOOTH_UNSIGNED_EN is defined.
interface booth_multiplier_seq_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_m;
  logic [WIDTH-1:0]     in_q;
`ifdef BOOTH_UNSIGNED_EN
  logic                 in_unsigned;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_z;
  logic                 busy;

  modport master (
`ifdef BOOTH_UNSIGNED_EN
    output in_unsigned,
`endif
    output in_valid, in_m, in_q, out_ready,
    input  in_ready, out_valid, out_z, busy
  );

  modport slave (
`ifdef BOOTH_UNSIGNED_EN
    input  in_unsigned,
`endif
    input  in_valid, in_m, in_q, out_ready,
    output in_ready, out_valid, out_z, busy
  );
endinterface

// File: rtl/booth_multiplier_seq_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A, Q, q_1}. Purely combinational.
module booth_multiplier_seq_step
  import booth_multiplier_seq_pkg::*;
#(
  parameter int AW = 33,
  parameter int QW = 32
) (
  input  logic [AW-1:0] i_a,
  input  logic [QW-1:0] i_q,
  input  logic          i_q1,
  input  logic [AW-1:0] i_m,
  output logic [AW-1:0] o_a,
  output logic [QW-1:0] o_q,
  output logic          o_q1
);

  logic [AW-1:0] w_sum;

  // Booth recoding of the current multiplier pair
  always_comb begin
    w_sum = i_a;
    case ({i_q[0], i_q1})
      PAIR_ADD: w_sum = i_a + i_m;
      PAIR_SUB: w_sum = i_a - i_m;
      default:  w_sum = i_a;
    endcase
  end

  assign o_a  = {w_sum[AW-1], w_sum[AW-1:1]};
  assign o_q  = {w_sum[0], i_q[QW-1:1]};
  assign o_q1 = i_q[0];

endmodule

// File: rtl/booth_multiplier_seq.sv
// Iterative radix-2 Booth multiplier, one step per clock, valid/ready in and out.
// Defining BOOTH_UNSIGNED_EN adds per-op unsigned operands at a cost of one step.
module booth_multiplier_seq
  import booth_multiplier_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  booth_multiplier_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam int AW    = WIDTH + 1;
  localparam int QW    = steps_for(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(QW - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [AW-1:0]    r_a;
  logic [AW-1:0]    r_m;
  logic [QW-1:0]    r_q;
  logic             r_q1;
  logic [CNT_W-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_out_z;
  logic             r_out_valid;

  logic [AW-1:0]    w_a_nxt;
  logic [QW-1:0]    w_q_nxt;
  logic             w_q1_nxt;
  logic [AW-1:0]    w_m_ext;
  logic [QW-1:0]    w_q_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic             w_accept;
  logic             w_last;
  logic             w_take;

`ifdef BOOTH_UNSIGNED_EN
  assign w_m_ext = {(bus.in_unsigned ? 1'b0 : bus.in_m[WIDTH-1]), bus.in_m};
  assign w_q_ext = {(bus.in_unsigned ? 1'b0 : bus.in_q[WIDTH-1]), bus.in_q};
  assign w_prod  = {w_a_nxt[WIDTH-2:0], w_q_nxt};
`else
  assign w_m_ext = {bus.in_m[WIDTH-1], bus.in_m};
  assign w_q_ext = bus.in_q;
  assign w_prod  = {w_a_nxt[WIDTH-1:0], w_q_nxt};
`endif

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_last   = (r_state == BUSY) && (r_cnt == LAST_STEP);
  assign w_take   = (r_state == DONE) && bus.out_ready;

  booth_multiplier_seq_step #(
    .AW (AW),
    .QW (QW)
  ) u_step (
    .i_a  (r_a),
    .i_q  (r_q),
    .i_q1 (r_q1),
    .i_m  (r_m),
    .o_a  (w_a_nxt),
    .o_q  (w_q_nxt),
    .o_q1 (w_q1_nxt)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_accept ? BUSY : IDLE;
      BUSY:    w_state_nxt = w_last ? DONE : BUSY;
      DONE:    w_state_nxt = bus.out_ready ? IDLE : DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand/accumulator registers, step counter and the held product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_m         <= '0;
      r_q         <= '0;
      r_q1        <= 1'b0;
      r_cnt       <= '0;
      r_out_z     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= '0;
        r_m   <= w_m_ext;
        r_q   <= w_q_ext;
        r_q1  <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == BUSY) begin
        r_a   <= w_a_nxt;
        r_q   <= w_q_nxt;
        r_q1  <= w_q1_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Product is captured straight from the final step so out_valid lands N_STEPS after accept
      if (w_last) begin
        r_out_z     <= w_prod;
        r_out_valid <= 1'b1;
      end else if (w_take) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_z     = r_out_z;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq: an 8-bit and a 32-bit instance
// checked against a plain-arithmetic product model; honours BOOTH_UNSIGNED_EN.
module tb_booth_multiplier_seq;

`ifdef BOOTH_UNSIGNED_EN
  localparam int N8  = 9;
  localparam int N32 = 33;
`else
  localparam int N8  = 8;
  localparam int N32 = 32;
`endif
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  booth_multiplier_seq_if #(.WIDTH(8))  if8 ();
  booth_multiplier_seq_if #(.WIDTH(32)) if32 ();

  booth_multiplier_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  booth_multiplier_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [15:0] ref8(input logic [7:0] m, input logic [7:0] q, input logic uns);
    logic signed [15:0] sm, sq;
    logic [15:0] um, uq;
    sm = {{8{m[7]}}, m};
    sq = {{8{q[7]}}, q};
    um = {8'd0, m};
    uq = {8'd0, q};
    return uns ? um * uq : sm * sq;
  endfunction

  function automatic logic [63:0] ref32(input logic [31:0] m, input logic [31:0] q, input logic uns);
    logic signed [63:0] sm, sq;
    logic [63:0] um, uq;
    sm = {{32{m[31]}}, m};
    sq = {{32{q[31]}}, q};
    um = {32'd0, m};
    uq = {32'd0, q};
    return uns ? um * uq : sm * sq;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if8.in_valid = 1'b0;  if8.in_m = 8'd0;   if8.in_q = 8'd0;   if8.out_ready = 1'b0;
    if32.in_valid = 1'b0; if32.in_m = 32'd0; if32.in_q = 32'd0; if32.out_ready = 1'b0;
`ifdef BOOTH_UNSIGNED_EN
    if8.in_unsigned = 1'b0;
    if32.in_unsigned = 1'b0;
`endif
  endtask

  // Drives one op, holds out_ready low for 'hold' cycles, returns product, latency, timeout
  task automatic do_op8(input logic [7:0] m, input logic [7:0] q, input int hold,
                        output logic [15:0] z, output int lat, output bit to);
    to = 1'b0;
    lat = 0;
    if8.in_m = m; if8.in_q = q; if8.in_valid = 1'b1; if8.out_ready = 1'b0;
    while (!if8.in_ready && lat < TMO) begin step(); lat++; end
    if (!if8.in_ready) to = 1'b1;
    step();
    if8.in_valid = 1'b0;
    lat = 0;
    while (!if8.out_valid && lat < TMO) begin step(); lat++; end
    if (!if8.out_valid) to = 1'b1;
    repeat (hold) step();
    z = if8.out_z;
    if8.out_ready = 1'b1;
    step();
    if8.out_ready = 1'b0;
  endtask

  task automatic do_op32(input logic [31:0] m, input logic [31:0] q, input int hold,
                         output logic [63:0] z, output int lat, output bit to);
    to = 1'b0;
    lat = 0;
    if32.in_m = m; if32.in_q = q; if32.in_valid = 1'b1; if32.out_ready = 1'b0;
    while (!if32.in_ready && lat < TMO) begin step(); lat++; end
    if (!if32.in_ready) to = 1'b1;
    step();
    if32.in_valid = 1'b0;
    lat = 0;
    while (!if32.out_valid && lat < TMO) begin step(); lat++; end
    if (!if32.out_valid) to = 1'b1;
    repeat (hold) step();
    z = if32.out_z;
    if32.out_ready = 1'b1;
    step();
    if32.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    n_checks++; if (if8.in_ready !== 1'b1)   begin n_errors++; $display("FAIL reset_in_ready8 got=%b want=1", if8.in_ready); end
    n_checks++; if (if8.out_valid !== 1'b0)  begin n_errors++; $display("FAIL reset_out_valid8 got=%b want=0", if8.out_valid); end
    n_checks++; if (if8.out_z !== 16'd0)     begin n_errors++; $display("FAIL reset_out_z8 got=%h want=0", if8.out_z); end
    n_checks++; if (if8.busy !== 1'b0)       begin n_errors++; $display("FAIL reset_busy8 got=%b want=0", if8.busy); end
    n_checks++; if (if32.in_ready !== 1'b1)  begin n_errors++; $display("FAIL reset_in_ready32 got=%b want=1", if32.in_ready); end
    n_checks++; if (if32.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid32 got=%b want=0", if32.out_valid); end
    n_checks++; if (if32.out_z !== 64'd0)    begin n_errors++; $display("FAIL reset_out_z32 got=%h want=0", if32.out_z); end
    n_checks++; if (if32.busy !== 1'b0)      begin n_errors++; $display("FAIL reset_busy32 got=%b want=0", if32.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic [63:0] z32;
    logic [15:0] z8;
    int lat;
    bit to;
    do_op32(32'd7, 32'hFFFF_FFFD, 0, z32, lat, to);
    n_checks++; if (z32 !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_errors++; $display("FAIL dir32_7x-3 got=%h want=ffffffffffffffeb", z32); end
    n_checks++; if (lat !== N32 || to) begin n_errors++; $display("FAIL dir32_latency got=%0d want=%0d to=%b", lat, N32, to); end
    do_op8(8'h80, 8'h80, 0, z8, lat, to);
    n_checks++; if (z8 !== 16'h4000) begin n_errors++; $display("FAIL dir8_min_x_min got=%h want=4000", z8); end
    n_checks++; if (lat !== N8 || to) begin n_errors++; $display("FAIL dir8_latency got=%0d want=%0d to=%b", lat, N8, to); end
    do_op8(8'h80, 8'h7F, 1, z8, lat, to);
    n_checks++; if (z8 !== 16'hC080) begin n_errors++; $display("FAIL dir8_min_x_max got=%h want=c080", z8); end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    int wait_cnt;
    exp = ref8(8'h35, 8'hF6, 1'b0);
    if8.in_m = 8'h35; if8.in_q = 8'hF6; if8.in_valid = 1'b1; if8.out_ready = 1'b0;
    step();
    if8.in_valid = 1'b0;
    wait_cnt = 0;
    while (!if8.out_valid && wait_cnt < TMO) begin step(); wait_cnt++; end
    n_checks++; if (!if8.out_valid) begin n_errors++; $display("FAIL bp_out_valid_timeout got=%b want=1", if8.out_valid); end
    if8.in_m = 8'h11; if8.in_q = 8'h22; if8.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (if8.out_z !== exp)      begin n_errors++; $display("FAIL bp_z_stable cyc=%0d got=%h want=%h", i, if8.out_z, exp); end
      n_checks++; if (if8.in_ready !== 1'b0)  begin n_errors++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, if8.in_ready); end
      n_checks++; if (if8.out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", i, if8.out_valid); end
      step();
    end
    if8.out_ready = 1'b1;
    step();
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b0;
    n_checks++; if (if8.out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_release_out_valid got=%b want=0", if8.out_valid); end
    n_checks++; if (if8.in_ready !== 1'b1)  begin n_errors++; $display("FAIL bp_release_in_ready got=%b want=1", if8.in_ready); end
    n_checks++; if (if8.busy !== 1'b0)      begin n_errors++; $display("FAIL bp_no_accept_in_done got=%b want=0", if8.busy); end
    step();
    n_checks++; if (if8.out_z !== exp)      begin n_errors++; $display("FAIL bp_z_held_idle got=%h want=%h", if8.out_z, exp); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m [3];
    logic [7:0] q [3];
    int cyc [3];
    int k, t;
    for (int i = 0; i < 3; i++) begin m[i] = 8'($urandom); q[i] = 8'($urandom); end
    k = 0;
    t = 0;
    if8.in_m = m[0]; if8.in_q = q[0]; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    while (k < 3 && t < 100) begin
      step();
      t++;
      if (if8.out_valid) begin
        cyc[k] = t;
        n_checks++; if (if8.out_z !== ref8(m[k], q[k], 1'b0)) begin n_errors++; $display("FAIL b2b_z op=%0d got=%h want=%h", k, if8.out_z, ref8(m[k], q[k], 1'b0)); end
        k++;
        if (k < 3) begin if8.in_m = m[k]; if8.in_q = q[k]; end
        else if8.in_valid = 1'b0;
      end
    end
    step();
    if8.out_ready = 1'b0;
    n_checks++; if (k !== 3) begin n_errors++; $display("FAIL b2b_timeout got=%0d ops want=3", k); end
    else begin
      n_checks++; if (cyc[1] - cyc[0] !== N8 + 2) begin n_errors++; $display("FAIL b2b_period0 got=%0d want=%0d", cyc[1] - cyc[0], N8 + 2); end
      n_checks++; if (cyc[2] - cyc[1] !== N8 + 2) begin n_errors++; $display("FAIL b2b_period1 got=%0d want=%0d", cyc[2] - cyc[1], N8 + 2); end
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] z32;
    int lat;
    bit to;
    if32.in_m = 32'd100; if32.in_q = 32'd200; if32.in_valid = 1'b1;
    step();
    if32.in_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    n_checks++; if (if32.out_valid !== 1'b0) begin n_errors++; $display("FAIL arst_out_valid got=%b want=0", if32.out_valid); end
    n_checks++; if (if32.busy !== 1'b0)      begin n_errors++; $display("FAIL arst_busy got=%b want=0", if32.busy); end
    n_checks++; if (if32.out_z !== 64'd0)    begin n_errors++; $display("FAIL arst_out_z32 got=%h want=0", if32.out_z); end
    n_checks++; if (if32.in_ready !== 1'b1)  begin n_errors++; $display("FAIL arst_in_ready got=%b want=1", if32.in_ready); end
    n_checks++; if (if8.out_z !== 16'd0)     begin n_errors++; $display("FAIL arst_out_z8 got=%h want=0", if8.out_z); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++; if (if32.busy !== 1'b0) begin n_errors++; $display("FAIL arst_idle_after got=%b want=0", if32.busy); end
    do_op32(32'd3, 32'd5, 0, z32, lat, to);
    n_checks++; if (z32 !== 64'd15) begin n_errors++; $display("FAIL arst_next_op got=%h want=f", z32); end
    n_checks++; if (lat !== N32 || to) begin n_errors++; $display("FAIL arst_next_latency got=%0d want=%0d to=%b", lat, N32, to); end
  endtask

  task automatic test_random();
    logic [7:0] corners [5];
    logic [7:0] m8, q8;
    logic [15:0] z8;
    logic [31:0] m32, q32;
    logic [63:0] z32;
    logic uns;
    int lat;
    bit to;
    corners[0] = 8'h80; corners[1] = 8'h7F; corners[2] = 8'h00; corners[3] = 8'h01; corners[4] = 8'hFF;
    for (int i = 0; i < 1500; i++) begin
      if (i < 25) begin m8 = corners[i / 5]; q8 = corners[i % 5]; end
      else begin m8 = 8'($urandom); q8 = 8'($urandom); end
      uns = 1'b0;
`ifdef BOOTH_UNSIGNED_EN
      uns = 1'($urandom);
      if8.in_unsigned = uns;
`endif
      do_op8(m8, q8, int'($urandom_range(0, 3)), z8, lat, to);
      n_checks++; if (z8 !== ref8(m8, q8, uns)) begin n_errors++; $display("FAIL rnd8 m=%h q=%h u=%b got=%h want=%h", m8, q8, uns, z8, ref8(m8, q8, uns)); end
      n_checks++; if (lat !== N8 || to) begin n_errors++; $display("FAIL rnd8_latency got=%0d want=%0d to=%b", lat, N8, to); end
    end
    for (int i = 0; i < 300; i++) begin
      m32 = $urandom;
      q32 = $urandom;
      if (i == 0) begin m32 = 32'h8000_0000; q32 = 32'h8000_0000; end
      uns = 1'b0;
`ifdef BOOTH_UNSIGNED_EN
      uns = 1'($urandom);
      if32.in_unsigned = uns;
`endif
      do_op32(m32, q32, int'($urandom_range(0, 3)), z32, lat, to);
      n_checks++; if (z32 !== ref32(m32, q32, uns)) begin n_errors++; $display("FAIL rnd32 m=%h q=%h u=%b got=%h want=%h", m32, q32, uns, z32, ref32(m32, q32, uns)); end
      n_checks++; if (lat !== N32 || to) begin n_errors++; $display("FAIL rnd32_latency got=%0d want=%0d to=%b", lat, N32, to); end
    end
    idle_inputs();
  endtask

`ifdef BOOTH_UNSIGNED_EN
  task automatic test_unsigned();
    logic [15:0] z8;
    int lat;
    bit to;
    if8.in_unsigned = 1'b1;
    do_op8(8'hFF, 8'hFF, 0, z8, lat, to);
    n_checks++; if (z8 !== 16'hFE01) begin n_errors++; $display("FAIL uns_ff_x_ff got=%h want=fe01", z8); end
    n_checks++; if (lat !== 9 || to) begin n_errors++; $display("FAIL uns_latency got=%0d want=9 to=%b", lat, to); end
    if8.in_unsigned = 1'b0;
    do_op8(8'hFF, 8'hFF, 0, z8, lat, to);
    n_checks++; if (z8 !== 16'h0001) begin n_errors++; $display("FAIL sgn_ff_x_ff got=%h want=0001", z8); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_random();
`ifdef BOOTH_UNSIGNED_EN
    test_unsigned();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
